// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter / countdown timer: presets from din (digits clamped to 9), counts to zero, pulses done.
// Latency: one clk per load or decrement; zero/busy/done are decoded from registers, so they follow the same edge.
// Backpressure: en=0 holds the count in RUN. Optional AUTO_RELOAD_EN restarts the count from the last load value after DONE.
module bcd_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   q,
    output logic                  zero,
    output logic                  busy,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state;
    logic [W-1:0]   din_clamped;
    logic [W-1:0]   q_dec;
    logic           borrow;

`ifdef AUTO_RELOAD_EN
    logic [W-1:0]   reload;
`endif

    // Clamp each preset digit to a legal BCD value.
    always_comb begin
        din_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (din[4*i +: 4] > 4'd9) begin
                din_clamped[4*i +: 4] = 4'd9;
            end else begin
                din_clamped[4*i +: 4] = din[4*i +: 4];
            end
        end
    end

    // Ripple-borrow BCD decrement: a zero digit that takes a borrow wraps to 9.
    always_comb begin
        q_dec  = q;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (q[4*i +: 4] == 4'd0) begin
                    q_dec[4*i +: 4] = 4'd9;
                end else begin
                    q_dec[4*i +: 4] = q[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q     <= '0;
            state <= IDLE;
`ifdef AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else if (load) begin
            q     <= din_clamped;
            state <= (din_clamped == '0) ? IDLE : RUN;
`ifdef AUTO_RELOAD_EN
            reload <= din_clamped;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                RUN: begin
                    if (en) begin
                        // Zero is absorbing; a RUN state with q already 0 just drops back to IDLE.
                        if (q == '0) begin
                            state <= IDLE;
                        end else begin
                            q     <= q_dec;
                            state <= (q_dec == '0) ? DONE : RUN;
                        end
                    end
                end
                DONE: begin
`ifdef AUTO_RELOAD_EN
                    if (reload != '0) begin
                        q     <= reload;
                        state <= RUN;
                    end else begin
                        q     <= '0;
                        state <= IDLE;
                    end
`else
                    q     <= '0;
                    state <= IDLE;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign zero = (q == '0);
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter (DIGITS=2); AUTO_RELOAD_EN section follows the same macro as the RTL.
module tb_bcd_down_counter;

    logic       clk;
    logic       clr;
    logic       load;
    logic [7:0] din;
    logic       en;
    logic [7:0] q;
    logic       zero;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_down_counter #(.DIGITS(2)) dut (
        .clk  (clk),
        .clr  (clr),
        .load (load),
        .din  (din),
        .en   (en),
        .q    (q),
        .zero (zero),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    initial begin
        clr  = 1'b1;
        load = 1'b0;
        din  = 8'h00;
        en   = 1'b0;

        // Reset from unknown state.
        step();
        step();
        chk("rst_q", q, 8'h00);
        chk("rst_zero", {7'd0, zero}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);

        // IDLE ignores en.
        clr = 1'b0;
        en  = 1'b1;
        step();
        chk("idle_en_q", q, 8'h00);
        chk("idle_en_busy", {7'd0, busy}, 8'd0);

        // Load 25 and count all the way down.
        load = 1'b1;
        din  = 8'h25;
        step();
        load = 1'b0;
        chk("ld25_q", q, 8'h25);
        chk("ld25_busy", {7'd0, busy}, 8'd1);
        for (int i = 1; i <= 25; i++) begin
            step();
            chk($sformatf("cnt25_q_%0d", i), q, to_bcd(25 - i));
            chk($sformatf("cnt25_done_%0d", i), {7'd0, done}, (i == 25) ? 8'd1 : 8'd0);
        end
        chk("cnt25_zero_end", {7'd0, zero}, 8'd1);
        chk("cnt25_busy_end", {7'd0, busy}, 8'd0);
        step();
        chk("after_done_q", q, 8'h00);
        chk("after_done_done", {7'd0, done}, 8'd0);
        chk("after_done_busy", {7'd0, busy}, 8'd0);
        step();
        chk("absorb_q", q, 8'h00);
        chk("absorb_done", {7'd0, done}, 8'd0);

        // Hold with en=0, then cross-digit borrow.
        load = 1'b1;
        din  = 8'h10;
        en   = 1'b0;
        step();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("hold_q_%0d", i), q, 8'h10);
            chk($sformatf("hold_busy_%0d", i), {7'd0, busy}, 8'd1);
        end
        en = 1'b1;
        step();
        chk("borrow_q", q, 8'h09);
        chk("borrow_zero", {7'd0, zero}, 8'd0);

        // Reload mid-count takes priority over decrement.
        load = 1'b1;
        din  = 8'h14;
        step();
        load = 1'b0;
        step();
        chk("pre_reload_q", q, 8'h13);
        load = 1'b1;
        din  = 8'h07;
        step();
        load = 1'b0;
        chk("reload_q", q, 8'h07);
        step();
        chk("resume_q1", q, 8'h06);
        step();
        chk("resume_q2", q, 8'h05);

        // Clamping of out-of-range digits.
        load = 1'b1;
        din  = 8'hF3;
        step();
        chk("clamp_hi_q", q, 8'h93);
        din = 8'hAF;
        step();
        chk("clamp_both_q", q, 8'h99);

        // Load of zero goes straight to IDLE without done.
        din = 8'h00;
        step();
        load = 1'b0;
        chk("ld0_q", q, 8'h00);
        chk("ld0_busy", {7'd0, busy}, 8'd0);
        chk("ld0_done", {7'd0, done}, 8'd0);
        step();
        chk("ld0_done_next", {7'd0, done}, 8'd0);

        // clr during RUN aborts without done.
        load = 1'b1;
        din  = 8'h40;
        step();
        load = 1'b0;
        en   = 1'b0;
        step();
        chk("run40_q", q, 8'h40);
        chk("run40_busy", {7'd0, busy}, 8'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("abort_q", q, 8'h00);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_done", {7'd0, done}, 8'd0);
        step();
        chk("abort_done_next", {7'd0, done}, 8'd0);

        // Short count: single-shot, or periodic with auto-reload.
        load = 1'b1;
        din  = 8'h03;
        en   = 1'b1;
        step();
        load = 1'b0;
        chk("p_q0", q, 8'h03);
        step(); chk("p_q1", q, 8'h02);
        step(); chk("p_q2", q, 8'h01);
        step(); chk("p_q3", q, 8'h00);
        chk("p_done3", {7'd0, done}, 8'd1);
`ifdef AUTO_RELOAD_EN
        step(); chk("ar_q4", q, 8'h03);
        chk("ar_done4", {7'd0, done}, 8'd0);
        chk("ar_busy4", {7'd0, busy}, 8'd1);
        step(); chk("ar_q5", q, 8'h02);
        step(); chk("ar_q6", q, 8'h01);
        step(); chk("ar_q7", q, 8'h00);
        chk("ar_done7", {7'd0, done}, 8'd1);
`else
        step(); chk("ss_q4", q, 8'h00);
        chk("ss_done4", {7'd0, done}, 8'd0);
        chk("ss_busy4", {7'd0, busy}, 8'd0);
        step(); chk("ss_q5", q, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
